hook_depth_ctrl: RTL and testbench
==================================

// Module: hook_depth_ctrl
// PURPOSE
//  Fishing-line controller; sits directly upstream of the hook/bait sprite renderer and drives its mode/mouse_v inputs.
//  - Owns the hook depth and the bait/hooked state.
//  - Converts cast/reel buttons and game events into a frame-rate depth trajectory.
//  - mouse_v is in tenths of a pixel; the renderer draws the sprite top at mouse_v/10, clamped to >= 62 px.
// PARAMETERS
//  SURFACE_V   620   depth at rest (62 px), tenths of px
//  MAX_V       4600  deepest hook position (460 px)
//  SINK_STEP   20    depth increase per frame_tick while sinking
//  REEL_STEP   40    depth decrease per frame_tick while reeling
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   synchronous reset, active low
//  frame_tick   in   1   one-cycle pulse per video frame
//  line_en      in   1   level: fishing scene active
//  cast_btn     in   1   level: hold to let line sink
//  reel_btn     in   1   level: hold to reel in
//  bait_load    in   1   pulse: attach bait
//  bite         in   1   pulse: fish touched hook (collision logic)
//  mode         out  2   0 stowed, 1 hook only, 2 hook+bait; 3 never driven
//  mouse_v      out  14  hook depth, tenths of px
//  hooked       out  1   fish on line
//  catch_pulse  out  1   one cycle when hooked fish reaches surface
// BEHAVIOUR
//  Interface and reset
//  - One clock domain; reset is synchronous and active-low: every output is loaded on a clk edge while rst_n==0.
//  - All outputs registered. Reset values: mode=0, mouse_v=SURFACE_V, hooked=0, catch_pulse=0, bait flag=0, state=STOWED.
//  - Depth changes only in the cycle after frame_tick (1-cycle latency). Button and event inputs are sampled every clk.
//  State machine (state_e: STOWED, READY, SINK, HOLD, REEL)
//  - STOWED: mode=0; mouse_v=SURFACE_V. Goes to READY when line_en=1.
//  - READY: hook at surface. bait_load sets the bait flag.
//    - cast_btn && !reel_btn -> SINK.
//  - SINK: on each frame_tick, depth += SINK_STEP, saturating at MAX_V.
//    - reel_btn -> REEL.
//    - !cast_btn -> HOLD.
//    - If depth reaches MAX_V, stay in SINK (held).
//  - HOLD: depth constant.
//    - reel_btn -> REEL; else cast_btn -> SINK.
//  - REEL: on each frame_tick, depth -= REEL_STEP, saturating at SURFACE_V.
//    - Reaching SURFACE_V -> READY.
//    - If hooked: catch_pulse=1 for exactly one cycle; hooked and bait flag clear.
//    - Releasing reel_btn with hooked=0 -> HOLD.
//    - With hooked=1, reel continues regardless of buttons.
//  Mode and events
//  - mode in READY/SINK/HOLD/REEL is 2 when bait flag=1, else 1.
//  - bite: honoured only in SINK/HOLD with bait flag=1. Effect: hooked=1, bait flag=0 (mode->1), forced -> REEL. Ignored otherwise.
//  - bait_load is ignored outside READY and while already baited.
//  Arithmetic and simultaneous events
//  - Compute in 15 bits and clamp before assigning to mouse_v; mouse_v never leaves [SURFACE_V, MAX_V] outside STOWED.
//  - cast_btn and reel_btn both high: reel wins.
//  - bite and reel_btn in the same cycle: bite processed (hooked=1).
//  - frame_tick coincident with a state change: the step uses the NEW state from the next tick; no step on the transition cycle.
//  - line_en falling in any state: next cycle -> STOWED, depth=SURFACE_V, hooked=0, bait flag=0; no catch_pulse.
//  - Reset mid-reel: immediate return to reset values.
// STRUCTURE
//  - Shared package fishing_pkg:
//    - state_e enum.
//    - MODE_STOWED/MODE_HOOK/MODE_BAIT constants (2'd0/1/2), shared with the renderer.
//    - SURFACE_V constant.
//  - Single module; no sub-module. Saturating add/sub is inline.
// TESTING
//  1. Reset, line_en=1 -> mode=1, mouse_v=620 next cycle; catch_pulse=0 throughout.
//  2. bait_load in READY, cast_btn held 10 ticks -> mode=2, mouse_v=820; release -> HOLD, depth holds at 820 over 5 ticks.
//  3. Cast held 300 ticks -> mouse_v saturates at 4600, never exceeds it.
//  4. Baited at 820, bite pulse -> hooked=1, mode=1, auto-reel: 620 after 5 ticks; catch_pulse high exactly one cycle; hooked=0.
//  5. Unbaited at 820, bite pulse -> ignored. reel+cast both high -> depth decreases by 40 per tick.
//  6. line_en drop or rst_n=0 mid-REEL at 1500 -> mode=0, mouse_v=620, hooked=0, no catch_pulse.

Source files
------------

// File: rtl/fishing_pkg.sv
// rtl/fishing_pkg.sv - shared fishing-line types and constants
package fishing_pkg;

  // Line controller states
  typedef enum logic [2:0] {
    STOWED,
    READY,
    SINK,
    HOLD,
    REEL
  } state_e;

  // Renderer mode encoding
  localparam logic [1:0] MODE_STOWED = 2'd0;
  localparam logic [1:0] MODE_HOOK   = 2'd1;
  localparam logic [1:0] MODE_BAIT   = 2'd2;

  // Hook depth at rest, tenths of a pixel (62 px)
  localparam logic [13:0] SURFACE_V = 14'd620;

endpackage

// File: rtl/hook_depth_ctrl.sv
// rtl/hook_depth_ctrl.sv - fishing-line hook depth and bait/hooked state controller
module hook_depth_ctrl
  import fishing_pkg::*;
#(
  parameter int MAX_V     = 4600,
  parameter int SINK_STEP = 20,
  parameter int REEL_STEP = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        line_en,
  input  logic        cast_btn,
  input  logic        reel_btn,
  input  logic        bait_load,
  input  logic        bite,
  output logic [1:0]  mode,
  output logic [13:0] mouse_v,
  output logic        hooked,
  output logic        catch_pulse
);

  // Depth arithmetic is done one bit wider so the add cannot wrap before clamping
  localparam logic [14:0] SURF_W = {1'b0, SURFACE_V};
  localparam logic [14:0] MAX_W  = 15'(MAX_V);
  localparam logic [14:0] SINK_W = 15'(SINK_STEP);
  localparam logic [14:0] REEL_W = 15'(REEL_STEP);

  state_e      state_q, state_d;
  logic [13:0] depth_q, depth_d;
  logic        bait_q, bait_d;
  logic        hooked_q, hooked_d;
  logic        catch_q, catch_d;
  logic [1:0]  mode_q, mode_d;

  logic [14:0] depth_w;
  logic [14:0] sink_sum;
  logic [14:0] sink_next;
  logic [14:0] reel_next;
  logic        bite_ok;

  // Saturating candidate depths for one sink or reel step
  always_comb begin
    depth_w   = {1'b0, depth_q};
    sink_sum  = depth_w + SINK_W;
    sink_next = (sink_sum > MAX_W) ? MAX_W : sink_sum;
    reel_next = (depth_w < SURF_W + REEL_W) ? SURF_W : depth_w - REEL_W;
    bite_ok   = bite && bait_q;
  end

  // Next-state, depth and flag logic; no depth step on a state-change cycle
  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    bait_d   = bait_q;
    hooked_d = hooked_q;
    catch_d  = 1'b0;

    if (!line_en) begin
      state_d  = STOWED;
      depth_d  = SURFACE_V;
      bait_d   = 1'b0;
      hooked_d = 1'b0;
    end else begin
      case (state_q)
        STOWED: begin
          state_d = READY;
          depth_d = SURFACE_V;
        end
        READY: begin
          if (bait_load) bait_d = 1'b1;
          if (cast_btn && !reel_btn) state_d = SINK;
        end
        SINK: begin
          if (bite_ok) begin
            hooked_d = 1'b1;
            bait_d   = 1'b0;
            state_d  = REEL;
          end else if (reel_btn) begin
            state_d = REEL;
          end else if (!cast_btn) begin
            state_d = HOLD;
          end else if (frame_tick) begin
            depth_d = sink_next[13:0];
          end
        end
        HOLD: begin
          if (bite_ok) begin
            hooked_d = 1'b1;
            bait_d   = 1'b0;
            state_d  = REEL;
          end else if (reel_btn) begin
            state_d = REEL;
          end else if (cast_btn) begin
            state_d = SINK;
          end
        end
        REEL: begin
          // A hooked fish keeps reeling in regardless of the buttons
          if (!hooked_q && !reel_btn) begin
            state_d = HOLD;
          end else if (frame_tick) begin
            depth_d = reel_next[13:0];
            if (reel_next == SURF_W) begin
              state_d = READY;
              if (hooked_q) begin
                catch_d  = 1'b1;
                hooked_d = 1'b0;
                bait_d   = 1'b0;
              end
            end
          end
        end
        default: begin
          state_d  = STOWED;
          depth_d  = SURFACE_V;
          bait_d   = 1'b0;
          hooked_d = 1'b0;
        end
      endcase
    end

    if (state_d == STOWED) mode_d = MODE_STOWED;
    else if (bait_d)       mode_d = MODE_BAIT;
    else                   mode_d = MODE_HOOK;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= STOWED;
      depth_q  <= SURFACE_V;
      bait_q   <= 1'b0;
      hooked_q <= 1'b0;
      catch_q  <= 1'b0;
      mode_q   <= MODE_STOWED;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      bait_q   <= bait_d;
      hooked_q <= hooked_d;
      catch_q  <= catch_d;
      mode_q   <= mode_d;
    end
  end

  assign mode        = mode_q;
  assign mouse_v     = depth_q;
  assign hooked      = hooked_q;
  assign catch_pulse = catch_q;

endmodule

// File: tb/tb_hook_depth_ctrl.sv
// tb/tb_hook_depth_ctrl.sv - self-checking bench for hook_depth_ctrl
module tb_hook_depth_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, frame_tick, line_en, cast_btn, reel_btn, bait_load, bite;
  logic [1:0]  mode;
  logic [13:0] mouse_v;
  logic        hooked, catch_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  hook_depth_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .line_en(line_en),
    .cast_btn(cast_btn), .reel_btn(reel_btn), .bait_load(bait_load), .bite(bite),
    .mode(mode), .mouse_v(mouse_v), .hooked(hooked), .catch_pulse(catch_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 stowed, 1 ready, 2 sinking, 3 holding, 4 reeling
  int m_phase, m_depth, m_bait, m_hooked, m_catch, m_mode;

  task automatic model_step(input logic r, le, t, c, rl, bl, bt);
    m_catch = 0;
    if (!r || !le) begin
      m_phase = 0; m_depth = 620; m_bait = 0; m_hooked = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (bl) m_bait = 1;
      if (c && !rl) m_phase = 2;
    end else if (m_phase == 2 || m_phase == 3) begin
      if (bt && m_bait == 1) begin
        m_hooked = 1; m_bait = 0; m_phase = 4;
      end else if (rl) m_phase = 4;
      else if (m_phase == 2 && !c) m_phase = 3;
      else if (m_phase == 3 && c) m_phase = 2;
      else if (m_phase == 2 && t) m_depth = (m_depth + 20 > 4600) ? 4600 : m_depth + 20;
    end else begin
      if (m_hooked == 0 && !rl) m_phase = 3;
      else if (t) begin
        m_depth = (m_depth - 40 < 620) ? 620 : m_depth - 40;
        if (m_depth == 620) begin
          m_phase = 1;
          if (m_hooked == 1) begin
            m_catch = 1; m_hooked = 0; m_bait = 0;
          end
        end
      end
    end
    m_mode = (m_phase == 0) ? 0 : (m_bait == 1 ? 2 : 1);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock cycle with the given inputs; outputs are stable 1ns after the edge
  task automatic cyc(input logic r, le, t, c, rl, bl, bt);
    rst_n = r; line_en = le; frame_tick = t; cast_btn = c;
    reel_btn = rl; bait_load = bl; bite = bt;
    @(posedge clk);
    model_step(r, le, t, c, rl, bl, bt);
    #1;
  endtask

  typedef struct {
    logic r, le, t, c, rl, bl, bt;
    int   mode, v, hk, cp;
  } vec_t;

  vec_t vecs[13];
  int   catches;
  int   maxv;
  bit   ok;

  initial begin
    // r le t c rl bl bt -> mode v hooked catch
    vecs[0]  = '{0,0,0,0,0,0,0, 0, 620, 0, 0};
    vecs[1]  = '{1,0,0,0,0,0,0, 0, 620, 0, 0};
    vecs[2]  = '{1,1,0,0,0,0,0, 1, 620, 0, 0};
    vecs[3]  = '{1,1,0,0,0,1,0, 2, 620, 0, 0};
    vecs[4]  = '{1,1,1,1,0,0,0, 2, 620, 0, 0};
    vecs[5]  = '{1,1,1,1,0,0,0, 2, 640, 0, 0};
    vecs[6]  = '{1,1,1,1,0,0,0, 2, 660, 0, 0};
    vecs[7]  = '{1,1,0,1,0,0,0, 2, 660, 0, 0};
    vecs[8]  = '{1,1,1,0,0,0,0, 2, 660, 0, 0};
    vecs[9]  = '{1,1,1,0,0,0,0, 2, 660, 0, 0};
    vecs[10] = '{1,1,0,0,1,0,1, 1, 660, 1, 0};
    vecs[11] = '{1,1,1,0,0,0,0, 1, 620, 0, 1};
    vecs[12] = '{1,1,1,0,0,0,0, 1, 620, 0, 0};

    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].r, vecs[i].le, vecs[i].t, vecs[i].c, vecs[i].rl, vecs[i].bl, vecs[i].bt);
      check($sformatf("vec%0d mode", i), int'(mode), vecs[i].mode);
      check($sformatf("vec%0d mouse_v", i), int'(mouse_v), vecs[i].v);
      check($sformatf("vec%0d hooked", i), int'(hooked), vecs[i].hk);
      check($sformatf("vec%0d catch", i), int'(catch_pulse), vecs[i].cp);
    end

    // Baited cast of 10 ticks, then hold over 5 ticks
    cyc(0,0,0,0,0,0,0);
    check("reset catch", int'(catch_pulse), 0);
    cyc(1,1,0,0,0,0,0);
    cyc(1,1,0,0,0,1,0);
    cyc(1,1,0,1,0,0,0);
    repeat (10) cyc(1,1,1,1,0,0,0);
    check("cast10 mode", int'(mode), 2);
    check("cast10 mouse_v", int'(mouse_v), 820);
    cyc(1,1,0,0,0,0,0);
    ok = 1;
    repeat (5) begin
      cyc(1,1,1,0,0,0,0);
      if (mouse_v != 14'd820) ok = 0;
    end
    check("hold steady", int'(ok), 1);

    // Bite while baited: auto-reel to surface with one catch pulse
    cyc(1,1,0,0,0,0,1);
    check("bite hooked", int'(hooked), 1);
    check("bite mode", int'(mode), 1);
    catches = 0;
    repeat (5) begin
      cyc(1,1,1,0,0,0,0);
      catches += int'(catch_pulse);
    end
    check("reel5 mouse_v", int'(mouse_v), 620);
    check("reel5 catch", int'(catch_pulse), 1);
    repeat (3) begin
      cyc(1,1,1,0,0,0,0);
      catches += int'(catch_pulse);
    end
    check("catch count", catches, 1);
    check("after catch hooked", int'(hooked), 0);

    // Long cast saturates at the bottom
    cyc(0,0,0,0,0,0,0);
    cyc(1,1,0,0,0,0,0);
    cyc(1,1,0,1,0,0,0);
    maxv = 0;
    repeat (300) begin
      cyc(1,1,1,1,0,0,0);
      if (int'(mouse_v) > maxv) maxv = int'(mouse_v);
    end
    check("saturate mouse_v", int'(mouse_v), 4600);
    check("saturate max", maxv, 4600);

    // Unbaited bite ignored; reel beats cast
    cyc(0,0,0,0,0,0,0);
    cyc(1,1,0,0,0,0,0);
    cyc(1,1,0,1,0,0,0);
    repeat (10) cyc(1,1,1,1,0,0,0);
    cyc(1,1,0,0,0,0,0);
    cyc(1,1,0,0,0,0,1);
    check("nobait bite hooked", int'(hooked), 0);
    check("nobait bite mouse_v", int'(mouse_v), 820);
    cyc(1,1,1,1,1,0,0);
    check("reel entry no step", int'(mouse_v), 820);
    cyc(1,1,1,1,1,0,0);
    check("reel+cast tick1", int'(mouse_v), 780);
    cyc(1,1,1,1,1,0,0);
    check("reel+cast tick2", int'(mouse_v), 740);

    // line_en drop and reset while reeling a fish from 1500
    for (int k = 0; k < 2; k++) begin
      cyc(0,0,0,0,0,0,0);
      cyc(1,1,0,0,0,0,0);
      cyc(1,1,0,0,0,1,0);
      cyc(1,1,0,1,0,0,0);
      repeat (44) cyc(1,1,1,1,0,0,0);
      cyc(1,1,0,1,0,0,1);
      check($sformatf("abort%0d start", k), int'(mouse_v), 1500);
      check($sformatf("abort%0d hooked", k), int'(hooked), 1);
      if (k == 0) cyc(1,0,1,0,0,0,0);
      else        cyc(0,1,1,0,0,0,0);
      check($sformatf("abort%0d mode", k), int'(mode), 0);
      check($sformatf("abort%0d mouse_v", k), int'(mouse_v), 620);
      check($sformatf("abort%0d hooked0", k), int'(hooked), 0);
      check($sformatf("abort%0d catch", k), int'(catch_pulse), 0);
    end

    // Randomized run against the reference model
    cyc(0,0,0,0,0,0,0);
    begin
      logic c_lvl, r_lvl, le_lvl;
      c_lvl = 0; r_lvl = 0; le_lvl = 1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 15) == 0) c_lvl = ~c_lvl;
        if ($urandom_range(0, 40) == 0) r_lvl = ~r_lvl;
        if ($urandom_range(0, 300) == 0) le_lvl = ~le_lvl;
        if ($urandom_range(0, 30) == 0) le_lvl = 1;
        cyc(logic'($urandom_range(0, 499) != 0), le_lvl,
            logic'($urandom_range(0, 2) == 0), c_lvl, r_lvl,
            logic'($urandom_range(0, 20) == 0), logic'($urandom_range(0, 25) == 0));
        n_checks++;
        if (int'(mode) == m_mode && int'(mouse_v) == m_depth &&
            int'(hooked) == m_hooked && int'(catch_pulse) == m_catch)
          n_pass++;
        else
          $display("FAIL random cycle %0d: got mode=%0d v=%0d hk=%0d cp=%0d expected mode=%0d v=%0d hk=%0d cp=%0d",
                   i, mode, mouse_v, hooked, catch_pulse, m_mode, m_depth, m_hooked, m_catch);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
